mem_responder: RTL

//  Memory-side responder for the multi-cycle MIPS-32 datapath: unified instruction/data word memory

---
 rtl/mem_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multi-cycle MIPS-32 datapath. A unified
// instruction/data word array that services MemRead/MemWrite requests from the
// control unit, inserting programmable wait states and signalling completion
// with a one-cycle MemReady pulse so the control FSM can stall on slow memory.
//
// Ports:
//   clock      rising-edge clock
//   Reset      asynchronous, active-high reset
//   MemRead    read request (level)
//   MemWrite   write request (level)
//   Address    byte address; word index = Address[ADDR_WIDTH+1:2]
//   WriteData  store data
//   MemData    registered read data, held until the next read completes
//   MemReady   one-cycle completion pulse
//   MemBusy    high whenever a transaction is in flight
//   AddrError  misaligned-access flag, pulses together with MemReady
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose
// Address[1:0] is non-zero. Without it, AddrError is tied low and the low
// address bits are ignored.

module mem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clock,
   input  logic                  Reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [31:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] MemData,
   output logic                  MemReady,
   output logic                  MemBusy,
   output logic                  AddrError
);

   typedef enum logic [1:0] {
      STATE_IDLE,
      STATE_WAIT,
      STATE_ACCESS,
      STATE_DONE
   } stateT;

   stateT                 state;
   stateT                 nextState;
   logic [3:0]            waitCount;
   logic [3:0]            nextWaitCount;
   logic                  accept;
   logic                  misalignReq;
   logic                  opWrite;
   logic [ADDR_WIDTH-1:0] wordIndex;
   logic [DATA_WIDTH-1:0] writeLatched;
   logic                  unusedAddrBits;

   logic [DATA_WIDTH-1:0] memArray [2**ADDR_WIDTH];

   // Upper address bits wrap away; the low byte-offset bits only matter when
   // alignment checking is compiled in.
   assign unusedAddrBits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

   assign accept = (state == STATE_IDLE) && (MemRead || MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned;

   assign misalignReq = (Address[1:0] != 2'b00);
   assign AddrError   = (state == STATE_DONE) && misaligned;

   // Remember whether the accepted request was rejected so AddrError can
   // accompany its MemReady pulse.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         misaligned <= 1'b0;
      end else if (accept) begin
         misaligned <= misalignReq;
      end
   end
`else
   assign misalignReq = 1'b0;
   assign AddrError   = 1'b0;
`endif

   assign MemReady = (state == STATE_DONE);
   assign MemBusy  = (state != STATE_IDLE);

   // State and wait-counter registers; reset aborts any transaction in flight.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state     <= STATE_IDLE;
         waitCount <= 4'd0;
      end else begin
         state     <= nextState;
         waitCount <= nextWaitCount;
      end
   end

   // Next-state logic. A rejected (misaligned) request skips straight to DONE
   // so the requester sees the error one cycle after acceptance.
   always_comb begin
      nextState     = state;
      nextWaitCount = waitCount;
      case (state)
         STATE_IDLE: begin
            if (accept) begin
               if (misalignReq) begin
                  nextState = STATE_DONE;
               end else if (WAIT_STATES == 0) begin
                  nextState = STATE_ACCESS;
               end else begin
                  nextState     = STATE_WAIT;
                  nextWaitCount = 4'(WAIT_STATES);
               end
            end
         end
         STATE_WAIT: begin
            nextWaitCount = waitCount - 4'd1;
            if (waitCount == 4'd1) begin
               nextState = STATE_ACCESS;
            end
         end
         STATE_ACCESS: begin
            nextState = STATE_DONE;
         end
         STATE_DONE: begin
            nextState = STATE_IDLE;
         end
         default: begin
            nextState = STATE_IDLE;
         end
      endcase
   end

   // Request capture: once accepted, the requester may change or drop its
   // inputs freely. Write wins when both strobes are high.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         opWrite      <= 1'b0;
         wordIndex    <= '0;
         writeLatched <= '0;
      end else if (accept) begin
         opWrite      <= MemWrite;
         wordIndex    <= Address[ADDR_WIDTH+1:2];
         writeLatched <= WriteData;
      end
   end

   // Array write. The array has no reset so its contents survive Reset; a
   // reset before the ACCESS edge leaves the state in IDLE and nothing commits.
   always_ff @(posedge clock) begin
      if (state == STATE_ACCESS && opWrite) begin
         memArray[wordIndex] <= writeLatched;
      end
   end

   // Read data register, updated only by completed reads.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         MemData <= '0;
      end else if (state == STATE_ACCESS && !opWrite) begin
         MemData <= memArray[wordIndex];
      end
   end

endmodule
